// File: rtl/seven_segment_scan_controller_if.sv
// Display-side bundle of the scan controller: BCD digits, blink/suppression
// controls in, anode enables and segment pattern out.
interface seven_segment_scan_controller_if;
   logic [3:0] digit0;
   logic [3:0] digit1;
   logic [3:0] digit2;
   logic [3:0] digit3;
   logic       blink_tick;
   logic [3:0] blink_mask;
   logic       lz_en;
   logic [3:0] an;
   logic [7:0] seg;

   modport master (
      output digit0, digit1, digit2, digit3, blink_tick, blink_mask, lz_en,
      input  an, seg
   );

   modport slave (
      input  digit0, digit1, digit2, digit3, blink_tick, blink_mask, lz_en,
      output an, seg
   );
endinterface

// File: rtl/seven_segment_scan_controller.sv
// Four-digit common-anode scan controller with dead-time, per-digit blink and
// leading-zero suppression, plus its active-low BCD segment decoder.
module seven_segment_display (
   input  logic [3:0] num_i,
   output logic [7:0] seg_o
);
   // seg bit 0 = segment a ... bit 6 = g, bit 7 = dp; all active-low
   always_comb begin
      case (num_i)
         4'h0:    seg_o = 8'b1100_0000;
         4'h1:    seg_o = 8'b1111_1001;
         4'h2:    seg_o = 8'b1010_0100;
         4'h3:    seg_o = 8'b1011_0000;
         4'h4:    seg_o = 8'b1001_1001;
         4'h5:    seg_o = 8'b1001_0010;
         4'h6:    seg_o = 8'b1000_0010;
         4'h7:    seg_o = 8'b1111_1000;
         4'h8:    seg_o = 8'b1000_0000;
         4'h9:    seg_o = 8'b1001_0000;
         default: seg_o = 8'b1111_1111;
      endcase
   end
endmodule

module seven_segment_scan_controller #(
   parameter int REFRESH_DIV = 100000,
   parameter int DEAD_CYCLES = 1000
) (
   input logic                          clk,
   input logic                          rst,
   seven_segment_scan_controller_if.slave disp
);
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);

   logic [CW-1:0] cnt_q,   cnt_d;
   logic [1:0]    idx_q,   idx_d;
   logic          blink_q, blink_d;
   logic [3:0]    an_q,    an_d;
   logic [3:0]    num_q,   num_d;
   logic [3:0]    lz_s;
   logic [3:0]    blank_s;
   logic [3:0]    dig_s;

   // Next-state: slot counter, digit index, blink phase and output registers
   always_comb begin
      cnt_d   = cnt_q + CW'(1);
      idx_d   = idx_q;
      blink_d = blink_q ^ disp.blink_tick;
      an_d    = 4'b1111;
      num_d   = 4'hF;

      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end else begin
         idx_d = idx_q;
      end

      // Suppression chains from the leftmost digit; digit0 always shows
      lz_s[3] = disp.lz_en & (disp.digit3 == 4'h0);
      lz_s[2] = lz_s[3] & (disp.digit2 == 4'h0);
      lz_s[1] = lz_s[2] & (disp.digit1 == 4'h0);
      lz_s[0] = 1'b0;
      blank_s = lz_s | (disp.blink_mask & {4{blink_q}});

      case (idx_q)
         2'd0:    dig_s = disp.digit0;
         2'd1:    dig_s = disp.digit1;
         2'd2:    dig_s = disp.digit2;
         2'd3:    dig_s = disp.digit3;
         default: dig_s = 4'hF;
      endcase

      if (cnt_q < CNT_DEAD) begin
         an_d  = 4'b1111;
         num_d = 4'hF;
      end else if (blank_s[idx_q]) begin
         an_d  = 4'b1111;
         num_d = 4'hF;
      end else begin
         an_d  = ~(4'b0001 << idx_q);
         num_d = dig_s;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         idx_q   <= 2'd0;
         blink_q <= 1'b0;
         an_q    <= 4'b1111;
         num_q   <= 4'hF;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         blink_q <= blink_d;
         an_q    <= an_d;
         num_q   <= num_d;
      end
   end

   seven_segment_display u_dec (
      .num_i (num_q),
      .seg_o (disp.seg)
   );

   assign disp.an = an_q;
endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed vector bench for the scan controller with a short slot (8 cycles,
// 2 dead cycles) so whole frames fit in a few hundred cycles.
module tb_seven_segment_scan_controller;
   localparam int DIV  = 8;
   localparam int DEAD = 2;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_fail;

   seven_segment_scan_controller_if dif ();

   seven_segment_scan_controller #(
      .REFRESH_DIV (DIV),
      .DEAD_CYCLES (DEAD)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .disp (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] digits;   // {digit3, digit2, digit1, digit0}
      logic [3:0]  mask;
      logic        lz;
      int          ticks;
      int          slot;
      logic [3:0]  an;
      logic [7:0]  seg;
   } vec_t;

   vec_t vecs [22];
   logic [7:0] seg_4321 [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string nm, logic [3:0] an_a, logic [7:0] seg_a,
                      logic [3:0] an_e, logic [7:0] seg_e);
      n_vec++;
      if (an_a !== an_e || seg_a !== seg_e) begin
         n_fail++;
         $display("FAIL %s: got an=%b seg=%h, want an=%b seg=%h",
                  nm, an_a, seg_a, an_e, seg_e);
      end
   endtask

   task automatic set_in(logic [15:0] d, logic [3:0] m, logic lz);
      dif.digit0     = d[3:0];
      dif.digit1     = d[7:4];
      dif.digit2     = d[11:8];
      dif.digit3     = d[15:12];
      dif.blink_mask = m;
      dif.lz_en      = lz;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      dif.blink_tick = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   task automatic set_vec(int i, logic [15:0] d, logic [3:0] m, logic lz,
                          int tk, int sl, logic [3:0] an, logic [7:0] sg);
      vecs[i].digits = d;
      vecs[i].mask   = m;
      vecs[i].lz     = lz;
      vecs[i].ticks  = tk;
      vecs[i].slot   = sl;
      vecs[i].an     = an;
      vecs[i].seg    = sg;
   endtask

   initial begin
      logic [3:0] exp_an;
      logic [7:0] exp_seg;
      int         tgt;
      int         s;
      int         sl;

      n_vec  = 0;
      n_fail = 0;
      seg_4321[0] = 8'hF9;
      seg_4321[1] = 8'hA4;
      seg_4321[2] = 8'hB0;
      seg_4321[3] = 8'h99;

      set_vec(0,  16'h4321, 4'b0000, 1'b0, 0, 0, 4'b1110, 8'hF9);
      set_vec(1,  16'h4321, 4'b0000, 1'b0, 0, 1, 4'b1101, 8'hA4);
      set_vec(2,  16'h4321, 4'b0000, 1'b0, 0, 2, 4'b1011, 8'hB0);
      set_vec(3,  16'h4321, 4'b0000, 1'b0, 0, 3, 4'b0111, 8'h99);
      set_vec(4,  16'h0050, 4'b0000, 1'b1, 0, 3, 4'b1111, 8'hFF);
      set_vec(5,  16'h0050, 4'b0000, 1'b1, 0, 2, 4'b1111, 8'hFF);
      set_vec(6,  16'h0050, 4'b0000, 1'b1, 0, 1, 4'b1101, 8'h92);
      set_vec(7,  16'h0050, 4'b0000, 1'b1, 0, 0, 4'b1110, 8'hC0);
      set_vec(8,  16'h0000, 4'b0000, 1'b1, 0, 0, 4'b1110, 8'hC0);
      set_vec(9,  16'h0000, 4'b0000, 1'b1, 0, 1, 4'b1111, 8'hFF);
      set_vec(10, 16'h0000, 4'b0000, 1'b0, 0, 3, 4'b0111, 8'hC0);
      set_vec(11, 16'h4321, 4'b0100, 1'b0, 1, 2, 4'b1111, 8'hFF);
      set_vec(12, 16'h4321, 4'b0100, 1'b0, 1, 1, 4'b1101, 8'hA4);
      set_vec(13, 16'h4321, 4'b0100, 1'b0, 2, 2, 4'b1011, 8'hB0);
      set_vec(14, 16'h43C1, 4'b0000, 1'b0, 0, 1, 4'b1101, 8'hFF);
      set_vec(15, 16'h8007, 4'b0000, 1'b0, 0, 3, 4'b0111, 8'h80);
      set_vec(16, 16'h8007, 4'b0000, 1'b0, 0, 0, 4'b1110, 8'hF8);
      set_vec(17, 16'h0609, 4'b0000, 1'b1, 0, 2, 4'b1011, 8'h82);
      set_vec(18, 16'h0609, 4'b0000, 1'b1, 0, 0, 4'b1110, 8'h90);
      set_vec(19, 16'h0609, 4'b0000, 1'b1, 0, 3, 4'b1111, 8'hFF);
      set_vec(20, 16'h0609, 4'b0000, 1'b1, 0, 1, 4'b1101, 8'hC0);
      set_vec(21, 16'h4321, 4'b0001, 1'b0, 1, 0, 4'b1111, 8'hFF);

      // Reset state
      set_in(16'h4321, 4'b0000, 1'b0);
      rst            = 1'b1;
      dif.blink_tick = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset_state", dif.an, dif.seg, 4'b1111, 8'hFF);
      end
      rst = 1'b0;

      // Table: reset, run to the first lit cycle of the chosen slot
      for (int v = 0; v < 22; v++) begin
         set_in(vecs[v].digits, vecs[v].mask, vecs[v].lz);
         do_reset();
         tgt = DEAD + 1 + DIV * vecs[v].slot;
         for (int e = 1; e <= tgt; e++) begin
            dif.blink_tick = (e <= vecs[v].ticks);
            tick();
            if (e == tgt - 1)
               chk($sformatf("vec%0d_dead", v), dif.an, dif.seg, 4'b1111, 8'hFF);
         end
         dif.blink_tick = 1'b0;
         chk($sformatf("vec%0d", v), dif.an, dif.seg, vecs[v].an, vecs[v].seg);
      end

      // Digit change mid-slot shows up one cycle later
      set_in(16'h4321, 4'b0000, 1'b0);
      do_reset();
      repeat (3) tick();
      chk("midslot_before", dif.an, dif.seg, 4'b1110, 8'hF9);
      dif.digit0 = 4'h7;
      tick();
      chk("midslot_after", dif.an, dif.seg, 4'b1110, 8'hF8);

      // blink_tick coincident with rst must not toggle the phase
      set_in(16'h4321, 4'b0100, 1'b0);
      rst            = 1'b1;
      dif.blink_tick = 1'b1;
      repeat (3) tick();
      rst            = 1'b0;
      dif.blink_tick = 1'b0;
      repeat (DEAD + 1 + DIV * 2) tick();
      chk("blink_tick_in_reset", dif.an, dif.seg, 4'b1011, 8'hB0);

      // Reset in the middle of the digit2 slot, then 10 frames of scanning
      set_in(16'h4321, 4'b0000, 1'b0);
      do_reset();
      repeat (DEAD + 3 + DIV * 2) tick();
      chk("digit2_lit", dif.an, dif.seg, 4'b1011, 8'hB0);
      rst = 1'b1;
      tick();
      chk("midslot_reset", dif.an, dif.seg, 4'b1111, 8'hFF);
      rst = 1'b0;
      for (int e = 1; e <= 40 * DIV; e++) begin
         tick();
         s  = (e - 1) % DIV;
         sl = ((e - 1) / DIV) % 4;
         if (s < DEAD) begin
            exp_an  = 4'b1111;
            exp_seg = 8'hFF;
         end else begin
            exp_an  = ~(4'b0001 << sl);
            exp_seg = seg_4321[sl];
         end
         chk($sformatf("scan_e%0d", e), dif.an, dif.seg, exp_an, exp_seg);
         n_vec++;
         if ($countones(~dif.an) > 1) begin
            n_fail++;
            $display("FAIL onehot_e%0d: got an=%b, want at most one low bit", e, dif.an);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule

// File: doc/seven_segment_scan_controller.md
Name: seven_segment_scan_controller

Overview:
- Time-multiplexes four BCD digits onto the shared 4-digit common-anode seven-segment display.
- Selects one digit per refresh slot, drives the active-low anode enables, and feeds that digit's value into an internal seven_segment_display decoder.
- Adds anode dead-time against ghosting, per-digit blinking, and leading-zero suppression.
- Sits between the stopwatch counter/mode logic and the board display pins.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); minimum 4.
- DEAD_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- digit0  input  4  rightmost digit value (BCD)
- digit1  input  4  digit value
- digit2  input  4  digit value
- digit3  input  4  leftmost digit value
- blink_tick  input  1  one-cycle pulse; toggles the blink phase
- blink_mask  input  4  bit i=1: digit i blinks
- lz_en  input  1  leading-zero suppression enable
- an  output  4  anode enables, active-low, bit i = digit i
- seg  output  8  segment pattern from the internal decoder, active-low, bit 7 = dp

Behaviour:
- Reset (rst=1 at a clk edge):
  - slot counter=0, digit index=0, blink_phase=0.
  - an=4'b1111, internal num register=4'hF, so seg=8'b11111111.
  - rst has priority over every other event, including blink_tick and a terminal count in the same cycle.
  - Reset mid-slot aborts that slot; scanning restarts at digit 0.
- Slot counter: counts 0..REFRESH_DIV-1, wraps to 0.
- Digit index: advances 0→1→2→3→0 on the cycle the counter wraps, i.e. one REFRESH_DIV-cycle slot per digit; full frame = 4*REFRESH_DIV cycles.
- Blink phase: toggles on each cycle with blink_tick=1 (and rst=0); otherwise holds.
- Digit i is blanked when any of the following holds:
  - blink_mask[i]=1 and blink_phase=1.
  - lz_en=1 and it is a leading zero:
    - digit3 is suppressed if digit3==0.
    - digit2 is suppressed if digit3==0 and digit2==0.
    - digit1 is suppressed if digit3, digit2 and digit1 are all 0.
    - digit0 is never suppressed, so all-zero shows "0".
- Output registers, one-cycle latency from the counter/index state. The registered values are based on the counter/index state of the previous cycle:
  - If counter < DEAD_CYCLES: an=4'b1111, num=4'hF.
  - Else if the current digit is blanked: an=4'b1111, num=4'hF.
  - Else: an = all ones except bit[index]=0, num = digit[index].
- Digit inputs are sampled every cycle. A change mid-slot appears on seg one cycle later; there is no frame-level latching.
- Values 4'hA–4'hF pass through to the decoder, which blanks them (seg=8'hFF); the anode is still driven.
- seg is the combinational decode of the registered num, so seg changes in the same cycle as an.
- At most one an bit is low at any time, and no an bit is low while counter < DEAD_CYCLES.

Test Plan:
1. REFRESH_DIV=8, DEAD_CYCLES=2; hold rst for 3 cycles, then release with digits=1,2,3,4 (digit0..3):
   - During reset: an=1111, seg=FF.
   - Cycles 1–2 after release: an=1111.
   - Cycle 3: an=1110, seg=8'b11111001.
   - At cycle 9, 10 and 11 the scan moves to digit 1: an=1111, then an=1101, seg=8'b10100100.
   - Full rotation 1110→1101→1011→0111 repeats every 32 cycles.
2. lz_en=1, digits3..0=0,0,5,0:
   - digit3 and digit2 slots keep an=1111.
   - digit1 shows 5 (8'b10010010); digit0 shows 0 (8'b11000000).
   - With all digits 0, only digit0 lights and shows 0.
3. blink_mask=4'b0100:
   - After one blink_tick, the digit2 slot stays an=1111 while other digits still light.
   - After a second blink_tick, digit2 lights again.
   - blink_tick coincident with rst leaves blink_phase=0.
4. digit1=4'hC: during the digit1 slot, an=1101 and seg=8'hFF.
5. Assert rst for 1 cycle in the middle of the digit2 slot:
   - The next cycle has an=1111.
   - The scan resumes at digit0 after the DEAD_CYCLES window.
   - Check that an never has two bits low across 10 frames.
